// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: IO window location, register
// offsets inside the window, address decode mask and CPU-style booleans.
package mem_responder_pkg;

    localparam logic [31:0] IO_BASE        = 32'h0003_0000;
    localparam logic [15:0] IO_DATA        = 16'h0000;
    localparam logic [15:0] IO_CTRL        = 16'h0004;
    localparam logic [31:0] IO_DECODE_MASK = 32'h0003_0000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // An address falls in the IO window when both decode bits are set.
    function automatic logic is_io(input logic [31:0] addr);
        return (addr & IO_DECODE_MASK) == IO_DECODE_MASK;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Byte-wide memory bus between memcontroller (master) and mem_responder (slave).
interface mem_responder_if;

    logic [31:0] mem_a;
    logic [7:0]  mem_din;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;

    modport master (output mem_a, mem_din, mem_wr, input mem_dout, io_buffer_full);
    modport slave  (input mem_a, mem_din, mem_wr, output mem_dout, io_buffer_full);

endinterface

// File: rtl/mem_responder_io_tx_fifo.sv
// Generic circular byte FIFO used as the UART TX queue. Push and pop in the
// same cycle are legal even when full; almost_full is registered so the
// writer sees it one cycle late and still has one slot of slack.
module io_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;
    logic             af_q;
    logic             do_push, do_pop;

    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CW'(DEPTH));
    assign data_o        = mem_q[head_q];
    assign count_o       = count_q;
    assign almost_full_o = af_q;

    // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
    assign do_pop  = en_i && pop_i && !empty_o;
    assign do_push = en_i && push_i && (!full_o || do_pop);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and registered almost-full flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            af_q    <= 1'b0;
        end else if (en_i) begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop)  head_q <= head_q + 1'b1;
            count_q <= count_d;
            af_q    <= (count_d >= CW'(DEPTH - 1));
        end
    end

    // Storage has no reset; only slots between head and tail are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push && rst_ni) mem_q[tail_q] <= data_i;
    end

endmodule

// File: rtl/mem_responder.sv
// Responder end of the memcontroller byte bus: main RAM plus the IO window
// (UART TX FIFO, one-byte RX holding register, program-done latch).
module mem_responder #(
    parameter int          RAM_ADDR_WIDTH = 17,
    parameter int          TX_FIFO_DEPTH  = 8,
    parameter logic [31:0] IO_BASE        = mem_responder_pkg::IO_BASE
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    mem_responder_if.slave    bus,
    output logic              io_overflow,
    output logic [7:0]        io_tx_data,
    output logic              io_tx_valid,
    input  logic              io_tx_ready,
    input  logic [7:0]        io_rx_data,
    input  logic              io_rx_valid,
    output logic              program_done
);
    import mem_responder_pkg::*;

    logic [7:0] ram [2**RAM_ADDR_WIDTH];

    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        rx_full_q, rx_full_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        overflow_q, overflow_d;
    logic        done_q, done_d;

    logic        acc_io, acc_rd;
    logic [15:0] io_off;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic        ram_we, tx_push, tx_full, tx_empty, tx_af, rx_clear;
    logic [$clog2(TX_FIFO_DEPTH):0] tx_count;
    logic        unused_bits;

    assign acc_io  = is_io(bus.mem_a);
    assign acc_rd  = !bus.mem_wr;
    assign io_off  = bus.mem_a[15:0] - IO_BASE[15:0];
    assign ram_idx = bus.mem_a[RAM_ADDR_WIDTH-1:0];

    assign ram_we   = rst_in && rdy_in && bus.mem_wr && !acc_io;
    assign tx_push  = bus.mem_wr && acc_io && (io_off == IO_DATA);
    assign rx_clear = rdy_in && acc_rd && acc_io && (io_off == IO_DATA) && rx_full_q;

    assign bus.mem_dout       = mem_dout_q;
    assign bus.io_buffer_full = tx_af;
    assign io_tx_valid        = !tx_empty;
    assign io_overflow        = overflow_q;
    assign program_done       = done_q;
    assign unused_bits        = ^{bus.mem_a, tx_count};

    io_tx_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk_i         (clk_in),
        .rst_ni        (rst_in),
        .en_i          (rdy_in),
        .push_i        (tx_push),
        .pop_i         (io_tx_ready),
        .data_i        (bus.mem_din),
        .data_o        (io_tx_data),
        .count_o       (tx_count),
        .full_o        (tx_full),
        .empty_o       (tx_empty),
        .almost_full_o (tx_af)
    );

    // RAM write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_idx] <= bus.mem_din;
    end

    // Read mux, RX capture/clear, sticky overflow and done flags.
    always_comb begin
        mem_dout_d = mem_dout_q;
        rx_full_d  = rx_full_q;
        rx_byte_d  = rx_byte_q;
        overflow_d = overflow_q;
        done_d     = done_q;
        if (acc_rd) begin
            if (acc_io) begin
                mem_dout_d = 8'h00;
                if (io_off == IO_DATA)      mem_dout_d = rx_full_q ? rx_byte_q : 8'h00;
                else if (io_off == IO_CTRL) mem_dout_d = {7'b0, rx_full_q};
            end else begin
                mem_dout_d = ram[ram_idx];
            end
        end
        // A byte arriving with the clearing read refills the holder.
        if (io_rx_valid && (!rx_full_q || rx_clear)) begin
            rx_byte_d = io_rx_data;
            rx_full_d = TRUE;
        end else if (rx_clear) begin
            rx_full_d = FALSE;
        end
        if (tx_push && tx_full && !io_tx_ready) overflow_d = TRUE;
        if (bus.mem_wr && acc_io && (io_off == IO_CTRL)) done_d = TRUE;
    end

    // State register; rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mem_dout_q <= '0;
            rx_full_q  <= 1'b0;
            rx_byte_q  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (rdy_in) begin
            mem_dout_q <= mem_dout_d;
            rx_full_q  <= rx_full_d;
            rx_byte_q  <= rx_byte_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: read results are queued when the
// read is issued and popped when mem_dout is sampled; TX bytes are queued
// when written and popped when the UART side accepts them.
module tb_mem_responder;

    logic       clk_in = 1'b0;
    logic       rst_in, rdy_in;
    logic       io_overflow, io_tx_valid, io_tx_ready, io_rx_valid, program_done;
    logic [7:0] io_tx_data, io_rx_data;

    mem_responder_if bus();

    mem_responder dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .bus          (bus),
        .io_overflow  (io_overflow),
        .io_tx_data   (io_tx_data),
        .io_tx_valid  (io_tx_valid),
        .io_tx_ready  (io_tx_ready),
        .io_rx_data   (io_rx_data),
        .io_rx_valid  (io_rx_valid),
        .program_done (program_done)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic wr);
        bus.mem_a   = a;
        bus.mem_din = d;
        bus.mem_wr  = wr;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst_in = 1'b0;
        drive(32'h0, 8'h0, 1'b0);
        step();
        step();
        exp = 8'h00;
        n_cmp++; if (bus.mem_dout !== exp) begin n_err++; $display("FAIL reset_dout: got %h want %h", bus.mem_dout, exp); end
        n_cmp++; if ({bus.io_buffer_full, io_overflow, io_tx_valid, program_done} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {bus.io_buffer_full, io_overflow, io_tx_valid, program_done});
        end
        rst_in = 1'b1;
    endtask

    task automatic test_ram();
        logic [7:0] exp;
        logic [7:0] pat [4];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        drive(32'h0000_0100, 8'hA5, 1'b1);
        step();
        n_cmp++; if (bus.mem_dout !== 8'h00) begin n_err++; $display("FAIL ram_wr_hold: got %h want 00", bus.mem_dout); end
        drive(32'h0000_0100, 8'h00, 1'b0);
        rd_q.push_back(8'hA5);
        step();
        exp = rd_q.pop_front();
        n_cmp++; if (bus.mem_dout !== exp) begin n_err++; $display("FAIL ram_roundtrip: got %h want %h", bus.mem_dout, exp); end
        for (int i = 0; i < 4; i++) begin
            drive(32'(i), pat[i], 1'b1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(32'(i), 8'h00, 1'b0);
            rd_q.push_back(pat[i]);
            step();
            exp = rd_q.pop_front();
            n_cmp++; if (bus.mem_dout !== exp) begin n_err++; $display("FAIL ram_b2b[%0d]: got %h want %h", i, bus.mem_dout, exp); end
        end
    endtask

    task automatic test_tx_flow();
        logic [7:0] exp;
        io_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(32'h0003_0000, 8'(8'h80 + i), 1'b1);
            if (i < 8) tx_q.push_back(8'(8'h80 + i));
            step();
            if (i == 5) begin
                n_cmp++; if (bus.io_buffer_full !== 1'b0) begin n_err++; $display("FAIL txf_full_6: got %b want 0", bus.io_buffer_full); end
            end
            if (i == 6) begin
                n_cmp++; if (bus.io_buffer_full !== 1'b1) begin n_err++; $display("FAIL txf_full_7: got %b want 1", bus.io_buffer_full); end
            end
            if (i == 7) begin
                n_cmp++; if (io_overflow !== 1'b0) begin n_err++; $display("FAIL txf_ovf_8: got %b want 0", io_overflow); end
            end
            if (i == 8) begin
                n_cmp++; if (io_overflow !== 1'b1) begin n_err++; $display("FAIL txf_ovf_9: got %b want 1", io_overflow); end
            end
        end
        drive(32'h0, 8'h00, 1'b0);
        io_tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp = tx_q.pop_front();
            n_cmp++; if (io_tx_valid !== 1'b1 || io_tx_data !== exp) begin
                n_err++; $display("FAIL txf_drain[%0d]: got v=%b d=%h want v=1 d=%h", k, io_tx_valid, io_tx_data, exp);
            end
            step();
            n_cmp++; if (bus.io_buffer_full !== (k == 0)) begin
                n_err++; $display("FAIL txf_full_drain[%0d]: got %b want %b", k, bus.io_buffer_full, (k == 0));
            end
        end
        n_cmp++; if (io_tx_valid !== 1'b0) begin n_err++; $display("FAIL txf_empty: got %b want 0", io_tx_valid); end
        io_tx_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got  = 0;
        logic [7:0] exp;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            io_tx_ready = (cyc % 2) == 1;
            if (sent < 20 && !bus.io_buffer_full) begin
                drive(32'h0003_0000, 8'(sent), 1'b1);
                tx_q.push_back(8'(sent));
                sent++;
            end else begin
                drive(32'h0, 8'h00, 1'b0);
            end
            if (io_tx_valid && io_tx_ready) begin
                if (tx_q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL wrap_spurious: got %h want no data", io_tx_data);
                end else begin
                    exp = tx_q.pop_front();
                    n_cmp++; if (io_tx_data !== exp) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", got, io_tx_data, exp); end
                end
                got++;
            end
            step();
        end
        drive(32'h0, 8'h00, 1'b0);
        io_tx_ready = 1'b0;
        n_cmp++; if (got != 20 || io_tx_valid !== 1'b0) begin
            n_err++; $display("FAIL wrap_count: got %0d bytes valid=%b want 20 bytes valid=0", got, io_tx_valid);
        end
    endtask

    task automatic test_rx();
        logic [7:0] exp;
        logic [31:0] ra [9];
        logic [7:0]  re [9];
        // RX byte pulses: 5A captured; later 11 captured, 22 dropped.
        drive(32'h0, 8'h00, 1'b0);
        io_rx_valid = 1'b1; io_rx_data = 8'h5A; step(); io_rx_valid = 1'b0;
        ra[0] = 32'h0003_0004; re[0] = 8'h01;
        ra[1] = 32'h0003_0000; re[1] = 8'h5A;
        ra[2] = 32'h0003_0004; re[2] = 8'h00;
        ra[3] = 32'h0003_0000; re[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            drive(ra[i], 8'h00, 1'b0);
            rd_q.push_back(re[i]);
            step();
            exp = rd_q.pop_front();
            n_cmp++; if (bus.mem_dout !== exp) begin n_err++; $display("FAIL rx_rd[%0d]: got %h want %h", i, bus.mem_dout, exp); end
        end
        drive(32'h0, 8'h00, 1'b0);
        io_rx_valid = 1'b1; io_rx_data = 8'h11; step();
        io_rx_data = 8'h22; step();
        // Clearing read coincides with a new byte.
        drive(32'h0003_0000, 8'h00, 1'b0);
        io_rx_data = 8'h33;
        rd_q.push_back(8'h11);
        step();
        io_rx_valid = 1'b0;
        exp = rd_q.pop_front();
        n_cmp++; if (bus.mem_dout !== exp) begin n_err++; $display("FAIL rx_clear_race: got %h want %h", bus.mem_dout, exp); end
        ra[4] = 32'h0003_0004; re[4] = 8'h01;
        ra[5] = 32'h0003_0000; re[5] = 8'h33;
        ra[6] = 32'h0003_0004; re[6] = 8'h00;
        ra[7] = 32'h0003_0008; re[7] = 8'h00;
        ra[8] = 32'h0000_0002; re[8] = 8'h33;
        for (int i = 4; i < 9; i++) begin
            drive(ra[i], 8'h00, 1'b0);
            rd_q.push_back(re[i]);
            step();
            exp = rd_q.pop_front();
            n_cmp++; if (bus.mem_dout !== exp) begin n_err++; $display("FAIL rx_rd[%0d]: got %h want %h", i, bus.mem_dout, exp); end
        end
    endtask

    task automatic test_halt_reset();
        logic [7:0] exp;
        logic [7:0] pat [4];
        pat[0] = 8'hDE; pat[1] = 8'hAD; pat[2] = 8'hBE; pat[3] = 8'hEF;
        drive(32'h0003_0004, 8'h00, 1'b1);
        step();
        n_cmp++; if (program_done !== 1'b1) begin n_err++; $display("FAIL halt_set: got %b want 1", program_done); end
        drive(32'h0, 8'h00, 1'b0);
        step(); step();
        n_cmp++; if (program_done !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %b want 1", program_done); end
        for (int i = 0; i < 7; i++) begin drive(32'h0003_0000, 8'(i), 1'b1); step(); end
        n_cmp++; if (bus.io_buffer_full !== 1'b1) begin n_err++; $display("FAIL halt_prefull: got %b want 1", bus.io_buffer_full); end
        for (int i = 0; i < 4; i++) begin drive(32'h0000_0200 + 32'(i), pat[i], 1'b1); step(); end
        drive(32'h0000_0100, 8'h00, 1'b0);
        step();
        drive(32'h0000_0201, 8'h00, 1'b0);
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
        n_cmp++; if ({program_done, io_overflow, bus.io_buffer_full, io_tx_valid} !== 4'b0000 || bus.mem_dout !== 8'h00) begin
            n_err++; $display("FAIL rst_mid: got flags=%b dout=%h want flags=0000 dout=00",
                {program_done, io_overflow, bus.io_buffer_full, io_tx_valid}, bus.mem_dout);
        end
        drive(32'h0000_0100, 8'h00, 1'b0);
        rd_q.push_back(8'hA5);
        step();
        exp = rd_q.pop_front();
        n_cmp++; if (bus.mem_dout !== exp) begin n_err++; $display("FAIL rst_ram_keep: got %h want %h", bus.mem_dout, exp); end
        for (int i = 0; i < 4; i++) begin
            drive(32'h0000_0200 + 32'(i), 8'h00, 1'b0);
            rd_q.push_back(pat[i]);
            step();
            exp = rd_q.pop_front();
            n_cmp++; if (bus.mem_dout !== exp) begin n_err++; $display("FAIL rst_ram[%0d]: got %h want %h", i, bus.mem_dout, exp); end
        end
    endtask

    task automatic test_rdy();
        logic [7:0] exp;
        io_tx_ready = 1'b0;
        drive(32'h0000_0400, 8'h77, 1'b1); step();
        drive(32'h0003_0000, 8'h66, 1'b1); step();
        drive(32'h0000_0400, 8'h00, 1'b0); step();
        rdy_in = 1'b0;
        io_tx_ready = 1'b1;
        io_rx_valid = 1'b1; io_rx_data = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            if (i % 2 == 0) drive(32'h0000_0400, 8'h99, 1'b1);
            else            drive(32'h0003_0000, 8'h55, 1'b1);
            step();
            n_cmp++; if (bus.mem_dout !== 8'h77 || io_tx_valid !== 1'b1 || io_tx_data !== 8'h66) begin
                n_err++; $display("FAIL rdy_hold[%0d]: got dout=%h v=%b d=%h want dout=77 v=1 d=66", i, bus.mem_dout, io_tx_valid, io_tx_data);
            end
        end
        io_rx_valid = 1'b0;
        rdy_in = 1'b1;
        io_tx_ready = 1'b0;
        drive(32'h0000_0400, 8'h00, 1'b0);
        rd_q.push_back(8'h77);
        step();
        exp = rd_q.pop_front();
        n_cmp++; if (bus.mem_dout !== exp) begin n_err++; $display("FAIL rdy_ram: got %h want %h", bus.mem_dout, exp); end
        drive(32'h0003_0004, 8'h00, 1'b0);
        rd_q.push_back(8'h00);
        io_tx_ready = 1'b1;
        step();
        io_tx_ready = 1'b0;
        exp = rd_q.pop_front();
        n_cmp++; if (bus.mem_dout !== exp) begin n_err++; $display("FAIL rdy_rx: got %h want %h", bus.mem_dout, exp); end
        n_cmp++; if (io_tx_valid !== 1'b0) begin n_err++; $display("FAIL rdy_fifo: got valid=%b want 0", io_tx_valid); end
    endtask

    initial begin
        rdy_in = 1'b1;
        io_tx_ready = 1'b0;
        io_rx_valid = 1'b0;
        io_rx_data = 8'h00;
        test_reset();
        test_ram();
        test_tx_flow();
        test_wrap();
        test_rx();
        test_halt_reset();
        test_rdy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the byte-wide memory bus that memcontroller drives (address, write data, write enable in; read data and io_buffer_full out).
- Contains the byte-addressed main RAM and the memory-mapped IO window: a UART TX FIFO, a one-byte RX holding register, and a program-done latch.
- Sits between memcontroller and the board/simulation IO; one byte is transferred per cycle.

Parameters:
- RAM_ADDR_WIDTH, 17, RAM is 2^17 bytes; RAM index is mem_a[RAM_ADDR_WIDTH-1:0].
- TX_FIFO_DEPTH, 8, entries in the IO TX FIFO; must be a power of two, at least 4.
- IO_BASE, 32'h0003_0000, start of the IO window.

Ports:
- clk_in  in  1  clock; all logic on rising edge.
- rst_in  in  1  reset; synchronous, active-low.
- rdy_in  in  1  global enable; when low, all registered state holds.
- mem_a  in  32  byte address from memcontroller.
- mem_din  in  8  write data from memcontroller.
- mem_wr  in  1  1 = write, 0 = read.
- mem_dout  out  8  registered read data.
- io_buffer_full  out  1  TX FIFO almost full (registered).
- io_overflow  out  1  sticky: a TX write was dropped.
- io_tx_data  out  8  head byte of the TX FIFO.
- io_tx_valid  out  1  TX FIFO not empty.
- io_tx_ready  in  1  UART accepts the head byte.
- io_rx_data  in  8  byte received from the UART.
- io_rx_valid  in  1  io_rx_data is valid this cycle.
- program_done  out  1  sticky halt flag.

Behaviour:
- Reset (rst_in==0 at a posedge) takes priority over rdy_in and clears:
  - mem_dout to 0, TX pointers/count to 0, io_buffer_full to 0;
  - io_overflow, rx_full, rx_byte and program_done to 0.
  - RAM contents are not cleared.
  - A reset in the middle of a multi-byte access aborts it; the next access starts clean.
- Decode: an access is IO iff mem_a[17:16]==2'b11 (IO_BASE..0x3FFFF); otherwise it is RAM.
- RAM read: mem_dout at cycle t+1 = ram[mem_a(t)]. Latency is exactly 1 cycle, and back-to-back reads are sustained.
- RAM write: at the posedge, ram[mem_a] <= mem_din. On that cycle mem_dout holds its previous value.
- IO reads (mem_dout one cycle later):
  - IO_BASE+0: rx_full ? rx_byte : 0. If rx_full, it is cleared at the same edge.
  - IO_BASE+4: {7'b0, rx_full}.
  - Any other IO offset: 0.
- IO writes:
  - IO_BASE+0 pushes mem_din into the TX FIFO.
  - IO_BASE+4 sets program_done. It stays set until reset.
  - Any other IO write is ignored.
- TX FIFO:
  - Circular buffer; head/tail pointers wrap modulo TX_FIFO_DEPTH; count is 0..DEPTH.
  - Pop happens when io_tx_valid && io_tx_ready.
  - Push and pop in the same cycle leave count unchanged. This is allowed even when full (the pop frees the slot).
  - A push while full with no pop is dropped and sets io_overflow.
  - A pop while empty cannot happen because valid is low.
  - io_buffer_full <= (next_count >= DEPTH-1), registered. This reserves one slot for the one-cycle lag seen by memcontroller.
- RX:
  - When io_rx_valid and !rx_full: capture rx_byte and set rx_full.
  - When io_rx_valid and rx_full: drop the byte, unless a clearing read of IO_BASE+0 happens in the same cycle. In that case the read returns the old byte, the new byte is captured, and rx_full stays 1.
- rdy_in low:
  - No RAM write, no FIFO push/pop, no RX capture, and mem_dout holds.
  - io_tx_valid and io_tx_data still reflect the current state.
- X-safety: mem_a with mem_wr==0 is always a read. Idle cycles (memcontroller driving address 0, read) only update mem_dout.

Decomposition:
- Shared package or header holds:
  - IO_BASE;
  - IO offsets (IO_DATA=0, IO_CTRL=4);
  - the IO decode mask (bits 17:16);
  - TRUE/FALSE macros already used by the CPU.
- One sub-module, io_tx_fifo:
  - generic byte FIFO with push, pop, data, count, full, empty, almost_full;
  - instantiated once.
- The RAM array, RX register and decode live in mem_responder.

Test Plan:
- RAM round trip: write 0xA5 to 0x00100, then read 0x00100 the next cycle → mem_dout = 0xA5 exactly one cycle later. Back-to-back reads of 0x0..0x3 holding 0x11,0x22,0x33,0x44 → four consecutive mem_dout values in that order.
- TX flow control: io_tx_ready=0, seven writes to 0x30000 → io_buffer_full rises the cycle after the 7th. An 8th write is accepted; a 9th sets io_overflow. Raising io_tx_ready drains the bytes in order, and io_buffer_full falls once count < 7.
- Wrap-around: push/pop 20 bytes (0..19) with io_tx_ready toggling every cycle → output sequence 0..19 with no loss. Count never exceeds 8.
- RX: pulse io_rx_valid with 0x5A → read 0x30004 gives 0x01. Read 0x30000 gives 0x5A, then a second read of 0x30004 gives 0x00. A second byte arriving while full is dropped. A byte arriving together with the clearing read is retained.
- Halt and reset: write to 0x30004 → program_done=1 and sticky. Drive rst_in=0 for one cycle mid-burst → program_done, io_overflow, io_buffer_full and mem_dout are 0, io_tx_valid is 0, and previously written RAM data still reads back.
- rdy_in low for 3 cycles during writes → RAM, FIFO and mem_dout unchanged; operation resumes correctly when rdy_in returns to 1.
